// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the instruction fetch front-end.
package fetch_prefetch_unit_pkg;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_STEP = 4;

    // Instruction word that stops sequential fetch and raises halt once consumed.
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    // Default first fetch address after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the core.
// Names keep their i_/o_ prefixes as seen from the fetch unit.
interface fetch_prefetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             i_redirect;
    logic [WIDTH-1:0] i_redirect_pc;

    logic             o_imem_req;
    logic [WIDTH-1:0] o_imem_addr;
    logic             i_imem_gnt;
    logic             i_imem_rvalid;
    logic [WIDTH-1:0] i_imem_rdata;

    logic             o_inst_valid;
    logic [WIDTH-1:0] o_inst;
    logic [WIDTH-1:0] o_inst_pc;
    logic             i_inst_ready;
    logic             o_halt;

    // Fetch unit side.
    modport master (
        input  i_redirect, i_redirect_pc,
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_inst_valid, o_inst, o_inst_pc,
        input  i_inst_ready,
        output o_halt
    );

    // Memory / core / branch unit side.
    modport slave (
        output i_redirect, i_redirect_pc,
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_inst_valid, o_inst, o_inst_pc,
        output i_inst_ready,
        input  o_halt
    );

endinterface

// File: rtl/fetch_prefetch_unit_queue.sv
// In-order queue of {pc, inst} entries. Head is read straight from storage,
// so a pushed entry becomes visible the cycle after the push. Flush wins
// over push and pop in the same cycle.
module fetch_queue #(
    parameter  int DATA_W = 64,
    parameter  int DEPTH  = 4,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              a_reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front-end: issues sequential word fetches under a
// credit limit, queues returned words with their PCs, handles redirects by
// flushing and discarding stale responses, and stops at the halt word.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input logic                   clk,
    input logic                   a_reset_n,
    fetch_prefetch_unit_if.master bus
);

    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int DW = $clog2(MAX_OUT) + 2;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + OW;

    logic [WIDTH-1:0]   fetch_pc;
    logic [WIDTH-1:0]   resp_pc;
    logic [OW-1:0]      outstanding;
    logic [DW-1:0]      discard;
    logic               fetch_stop;
    logic               halt_q;

    logic [2*WIDTH-1:0] q_head;
    logic [CW-1:0]      q_count;
    logic               q_empty;
    logic               q_full;

    logic               redirect_en;
    logic               credit_ok;
    logic               issue;
    logic               rsp_drop;
    logic               rsp_keep;
    logic               push;
    logic               pop;

    // Redirects are ignored once halted.
    assign redirect_en = bus.i_redirect & ~halt_q;

    // A response only takes a queue slot if every in-flight request and
    // every queued entry fit in the queue together.
    assign credit_ok = ~q_full & (outstanding < OW'(MAX_OUT))
                     & ((SW'(q_count) + SW'(outstanding)) < SW'(DEPTH));

    assign bus.o_imem_req  = a_reset_n & ~fetch_stop & ~halt_q & ~bus.i_redirect & credit_ok;
    assign bus.o_imem_addr = fetch_pc;
    assign issue           = bus.o_imem_req & bus.i_imem_gnt;

    // Responses are dropped while stale ones are still owed; a response
    // landing in a redirect cycle is stale as well, so it is not pushed.
    assign rsp_drop = bus.i_imem_rvalid & (discard != '0);
    assign rsp_keep = bus.i_imem_rvalid & (discard == '0);
    assign push     = rsp_keep & ~redirect_en;
    assign pop      = bus.o_inst_valid & bus.i_inst_ready & ~redirect_en;

    fetch_queue #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .push      (push),
        .push_data ({resp_pc, bus.i_imem_rdata}),
        .pop       (pop),
        .flush     (redirect_en),
        .head_data (q_head),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign bus.o_inst_valid = ~q_empty;
    assign bus.o_inst       = q_head[WIDTH-1:0];
    assign bus.o_inst_pc    = q_head[2*WIDTH-1:WIDTH];
    assign bus.o_halt       = halt_q;

    // Fetch/response PCs and the in-flight bookkeeping. On redirect, every
    // request not yet answered after this cycle becomes a response to drop.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fetch_stop  <= 1'b0;
        end else if (redirect_en) begin
            fetch_pc    <= bus.i_redirect_pc;
            resp_pc     <= bus.i_redirect_pc;
            outstanding <= '0;
            discard     <= discard - DW'(rsp_drop) + DW'(outstanding) - DW'(rsp_keep);
            fetch_stop  <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
            end
            if (push) begin
                resp_pc <= resp_pc + WIDTH'(PC_STEP);
            end
            outstanding <= outstanding + OW'(issue) - OW'(rsp_keep);
            discard     <= discard - DW'(rsp_drop);
            if (push && (bus.i_imem_rdata == WIDTH'(HALT_WORD))) begin
                fetch_stop <= 1'b1;
            end
        end
    end

    // Sticky halt once the core consumes the halt word.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            halt_q <= 1'b0;
        end else if (pop && (bus.o_inst == WIDTH'(HALT_WORD))) begin
            halt_q <= 1'b1;
        end
    end

endmodule
